// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator car controller.
// Optional emergency stop: define ELEVATOR_ESTOP_EN.
package elevator_pkg;

    localparam int DEF_NUM_FLOORS = 7;
    localparam int DEF_FLOOR_W    = 3;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        ARRIVE,
        DOOR_OPEN
    } car_state_e;

    // Counter width able to hold 0..n-1, never zero bits wide.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_car_controller_if.sv
// Request-queue / direction-resolver bus seen by the car controller.
// Optional emergency stop (ELEVATOR_ESTOP_EN) is a plain port, not here.
interface elevator_car_controller_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
);

    logic [NUM_FLOORS-1:0] queue_status;
    logic                  queue_empty;
    logic                  next_up_ndown;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  current_up_ndown;
    logic                  serve_valid;
    logic [FLOOR_W-1:0]    serve_floor;

    modport master (
        input  queue_status,
        input  queue_empty,
        input  next_up_ndown,
        output current_floor,
        output current_up_ndown,
        output serve_valid,
        output serve_floor
    );

    modport slave (
        output queue_status,
        output queue_empty,
        output next_up_ndown,
        input  current_floor,
        input  current_up_ndown,
        input  serve_valid,
        input  serve_floor
    );

endinterface

// File: rtl/elevator_cycle_timer.sv
// Loadable down-counter shared by travel and door dwell timing.
// Saturates at zero; load wins over enable.
module elevator_cycle_timer
    import elevator_pkg::*;
#(
    parameter int MAX = 16,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         enable_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Count register: reload, or step down toward zero when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Sequencing FSM for one elevator car: travel, arrival and door dwell.
// Define ELEVATOR_ESTOP_EN to add the estop input (freeze in place).
module elevator_car_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset,
`ifdef ELEVATOR_ESTOP_EN
    input  logic estop,
`endif
    input  logic door_hold,
    output logic moving,
    output logic door_open,
    elevator_car_controller_if.master bus
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                          TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW = cnt_w(TMAX);
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP  = FLOOR_W'(NUM_FLOORS - 1);

    car_state_e         state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               up_q, up_d;
    logic               moving_q, moving_d;
    logic               door_q, door_d;
    logic               sv_q, sv_d;
    logic [FLOOR_W-1:0] sf_q, sf_d;

    logic          t_load;
    logic [TW-1:0] t_val;
    logic          t_en;
    logic          t_zero;
    logic          stop;
    logic          here;

`ifdef ELEVATOR_ESTOP_EN
    assign stop = estop;
`else
    assign stop = 1'b0;
`endif

    assign here = bus.queue_status[floor_q];

    // Never point the car past either end of the shaft.
    function automatic logic clamp(input logic d,
                                   input logic [FLOOR_W-1:0] f);
        if ((d == UP) && (f == TOP)) return DOWN;
        if ((d == DOWN) && (f == '0)) return UP;
        return d;
    endfunction

    elevator_cycle_timer #(
        .MAX (TMAX),
        .W   (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (t_load),
        .value_i  (t_val),
        .enable_i (t_en),
        .zero_o   (t_zero)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            up_q     <= UP;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
            sv_q     <= 1'b0;
            sf_q     <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            up_q     <= up_d;
            moving_q <= moving_d;
            door_q   <= door_d;
            sv_q     <= sv_d;
            sf_q     <= sf_d;
        end
    end

    // Next state, next outputs and timer control.
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        up_d     = up_q;
        moving_d = 1'b0;
        door_d   = 1'b0;
        sv_d     = 1'b0;
        sf_d     = sf_q;
        t_load   = 1'b0;
        t_val    = TRAVEL_LD;
        t_en     = 1'b0;

        unique case (state_q)
            IDLE, ARRIVE: begin
                if (here) begin
                    state_d = DOOR_OPEN;
                    door_d  = 1'b1;
                    sv_d    = 1'b1;
                    sf_d    = floor_q;
                    t_load  = 1'b1;
                    t_val   = DOOR_LD;
                end else if (bus.queue_empty) begin
                    state_d = IDLE;
                end else if (!stop) begin
                    state_d  = MOVE;
                    up_d     = clamp(bus.next_up_ndown, floor_q);
                    moving_d = 1'b1;
                    t_load   = 1'b1;
                    t_val    = TRAVEL_LD;
                end
            end
            MOVE: begin
                if (!stop) begin
                    t_en = 1'b1;
                    if (t_zero) begin
                        state_d = ARRIVE;
                        floor_d = up_q ? floor_q + FLOOR_W'(1)
                                       : floor_q - FLOOR_W'(1);
                    end else begin
                        moving_d = 1'b1;
                    end
                end
            end
            DOOR_OPEN: begin
                door_d = 1'b1;
                // The bit is still set during the pulse cycle; ignore it.
                if (here && !sv_q) begin
                    sv_d = 1'b1;
                    sf_d = floor_q;
                end
                if (door_hold || (here && !sv_q)) begin
                    t_load = 1'b1;
                    t_val  = DOOR_LD;
                end else if (!stop) begin
                    if (t_zero) begin
                        state_d = IDLE;
                        door_d  = 1'b0;
                    end else begin
                        t_en = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign moving               = moving_q;
    assign door_open            = door_q;
    assign bus.current_floor    = floor_q;
    assign bus.current_up_ndown = up_q;
    assign bus.serve_valid      = sv_q;
    assign bus.serve_floor      = sf_q;

endmodule
